// File: rtl/mem_access_arbiter.sv
// ---------------------------------------------------------------------------
// mem_access_arbiter
//
// Shares the single unified instruction/data memory of the multicycle MIPS
// core between the core's memory stage (CPU) and the program loader / debug
// host (LDR). One access is in flight at a time:
//   IDLE   -> arbitrate, latch owner/we/addr/wdata
//   ACCESS -> mem_en on the first cycle, wait MEM_LATENCY cycles, capture data
//   RESP   -> one-cycle ack to the owner
// The CPU wins by default; the loader is forced through after STARVE_LIMIT
// consecutive CPU grants made while it was waiting.
//
// Optional build macro: MEM_ARB_ALIGN_CHECK_EN
//   Adds output cpu_err. A CPU request whose address is not word aligned skips
//   the memory entirely and is acknowledged with cpu_err=1 in its RESP cycle.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   cpu_req/we/addr/wdata     CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack        CPU read data (held until next CPU read), ack pulse
//   cpu_stall                 cpu_req && !cpu_ack, forced low during reset
//   ldr_req/we/addr/wdata     loader request, held until ldr_ack
//   ldr_rdata, ldr_ack        loader read data, ack pulse
//   mem_en, mem_we            memory strobe (one cycle per access), write enable
//   mem_addr, mem_wdata       latched address / write data (hold between accesses)
//   mem_rdata                 memory read data
//   busy                      high whenever the FSM is not IDLE
//   cpu_err                   (MEM_ARB_ALIGN_CHECK_EN only) misaligned CPU access
// ---------------------------------------------------------------------------
module mem_access_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_stall,
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  output logic [DATA_WIDTH-1:0] ldr_rdata,
  output logic                  ldr_ack,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
`ifdef MEM_ARB_ALIGN_CHECK_EN
  output logic                  cpu_err,
`endif
  output logic                  busy
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT  = CNT_W'(MEM_LATENCY - 1);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;   // 1 = loader owns the access
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]      wait_q, wait_d;
  logic [STV_W-1:0]      starve_q, starve_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] ldr_rdata_q, ldr_rdata_d;
  logic                  ldr_win;
`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic                  err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    starve_d    = starve_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    err_d       = 1'b0;
`endif
    // Loader wins only when alone, or when the CPU has starved it long enough.
    ldr_win = ldr_req && (!cpu_req || (starve_q == STARVE_MAX));

    case (state_q)
      ST_IDLE: begin
        if (cpu_req || ldr_req) begin
          owner_d = ldr_win;
          we_d    = ldr_win ? ldr_we    : cpu_we;
          addr_d  = ldr_win ? ldr_addr  : cpu_addr;
          wdata_d = ldr_win ? ldr_wdata : cpu_wdata;
          wait_d  = '0;
          state_d = ST_ACCESS;
          if (ldr_win) begin
            starve_d = '0;
          end else if (ldr_req && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + STV_W'(1);
          end
`ifdef MEM_ARB_ALIGN_CHECK_EN
          // Misaligned CPU access never reaches memory; answer it with an error.
          if (!ldr_win && (cpu_addr[1:0] != 2'b00)) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end
`endif
        end
      end

      ST_ACCESS: begin
        if (wait_q == LAST_WAIT) begin
          if (!we_q) begin
            if (owner_q) ldr_rdata_d = mem_rdata;
            else         cpu_rdata_d = mem_rdata;
          end
          state_d = ST_RESP;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_q      <= '0;
      starve_q    <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  // The strobe is the first ACCESS cycle only; the counter is still zero there.
  assign mem_en    = (state_q == ST_ACCESS) && (wait_q == '0);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ack   = (state_q == ST_RESP) && !owner_q;
  assign ldr_ack   = (state_q == ST_RESP) && owner_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign cpu_stall = !rst && cpu_req && !cpu_ack;
`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign cpu_err   = err_q;
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Testbench for mem_access_arbiter. Two instances (MEM_LATENCY 1 and 3) run
// directed then random traffic against a transaction-timing model.
module tb_mem_access_arbiter;
  localparam int SLIM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
      localparam int LAT = (gi == 0) ? 1 : 3;

      logic        rst, cpu_req, cpu_we, ldr_req, ldr_we;
      logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata, mem_rdata;
      logic [31:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata;
      logic        cpu_ack, cpu_stall, ldr_ack, mem_en, mem_we, busy;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      logic        cpu_err;
`endif
      bit          fin = 1'b0;

      // next-cycle stimulus, applied at the falling edge inside step()
      logic        nx_rst, nx_cpu_req, nx_cpu_we, nx_ldr_req, nx_ldr_we;
      logic [31:0] nx_cpu_addr, nx_cpu_wdata, nx_ldr_addr, nx_ldr_wdata;

      mem_access_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)
      ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
`ifdef MEM_ARB_ALIGN_CHECK_EN
        .cpu_err(cpu_err),
`endif
        .busy(busy)
      );

      // environment memory (reacts to DUT strobes) and model memory (reacts to model grants)
      logic [31:0] env_mem [16];
      logic [31:0] mdl_mem [16];
      int          rd_pend;
      logic [3:0]  rd_idx;

      // transaction model: grant cycle, strobe cycle and ack cycle of the current access
      int          cyc;
      bit          have, t_owner, t_we, t_err;
      int          t_en, t_ack;
      logic [31:0] t_addr;
      logic [31:0] m_addr, m_wdata, m_cpu_rdata, m_ldr_rdata;
      int          m_starve;

      // observations from directed transactions
      int          ob_en_cnt, ob_en_off, ob_ack_off;
      logic        ob_we, ob_err, ob_stall0;
      logic [31:0] ob_addr, ob_wdata, ob_rdata;

      task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL L=%0d %s @cycle %0d: got 0x%08h, want 0x%08h", LAT, name, cyc, act, exp);
      endtask

      task automatic chk1(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL L=%0d %s @cycle %0d: got %b, want %b", LAT, name, cyc, act, exp);
      endtask

      task automatic model_reset();
        have        = 1'b0;
        t_err       = 1'b0;
        m_addr      = '0;
        m_wdata     = '0;
        m_cpu_rdata = '0;
        m_ldr_rdata = '0;
        m_starve    = 0;
      endtask

      // One clock cycle: serve memory, apply stimulus, compare, advance the model.
      task automatic step();
        bit idle, en_e, cack_e, lack_e, lwin;
        @(negedge clk);
        if (mem_en) begin
          if (mem_we) env_mem[mem_addr[5:2]] = mem_wdata;
          else begin
            rd_pend = LAT;
            rd_idx  = mem_addr[5:2];
          end
        end
        // valid data only in the cycle the latency says it is due
        if (rd_pend == 1) mem_rdata = env_mem[rd_idx];
        else              mem_rdata = $urandom();
        if (rd_pend > 0) rd_pend--;

        rst = nx_rst;
        cpu_req = nx_cpu_req; cpu_we = nx_cpu_we; cpu_addr = nx_cpu_addr; cpu_wdata = nx_cpu_wdata;
        ldr_req = nx_ldr_req; ldr_we = nx_ldr_we; ldr_addr = nx_ldr_addr; ldr_wdata = nx_ldr_wdata;
        #1;
        if (rst) model_reset();
        idle   = !have || (cyc > t_ack);
        en_e   = have && !t_err && (cyc == t_en);
        cack_e = have && (cyc == t_ack) && !t_owner;
        lack_e = have && (cyc == t_ack) && t_owner;
        chk1("busy", busy, !idle);
        chk1("mem_en", mem_en, en_e);
        chk1("mem_we", mem_we, en_e && t_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk1("cpu_ack", cpu_ack, cack_e);
        chk1("ldr_ack", ldr_ack, lack_e);
        chk("cpu_rdata", cpu_rdata, m_cpu_rdata);
        chk("ldr_rdata", ldr_rdata, m_ldr_rdata);
        chk1("cpu_stall", cpu_stall, !rst && cpu_req && !cack_e);
`ifdef MEM_ARB_ALIGN_CHECK_EN
        chk1("cpu_err", cpu_err, cack_e && t_err);
`endif
        if (!rst) begin
          if (have && (cyc + 1 == t_ack) && !t_we && !t_err) begin
            if (t_owner) m_ldr_rdata = mdl_mem[t_addr[5:2]];
            else         m_cpu_rdata = mdl_mem[t_addr[5:2]];
          end
          if (idle && (cpu_req || ldr_req)) begin
            lwin = ldr_req && (!cpu_req || (m_starve == SLIM));
            if (lwin) m_starve = 0;
            else if (ldr_req && (m_starve < SLIM)) m_starve++;
            t_owner = lwin;
            t_we    = lwin ? ldr_we : cpu_we;
            t_addr  = lwin ? ldr_addr : cpu_addr;
            m_addr  = t_addr;
            m_wdata = lwin ? ldr_wdata : cpu_wdata;
            t_err   = 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
            t_err   = !lwin && (cpu_addr[1:0] != 2'b00);
`endif
            t_en    = cyc + 1;
            t_ack   = t_err ? cyc + 1 : cyc + 1 + LAT;
            have    = 1'b1;
            if (t_we && !t_err) mdl_mem[t_addr[5:2]] = m_wdata;
          end
        end
        cyc++;
      endtask

      // Issue one request, wait (bounded) for its ack, then one idle cycle.
      task automatic run_txn(input bit is_ldr, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata);
        int n0;
        n0 = cyc;
        ob_en_cnt = 0; ob_en_off = -1; ob_ack_off = -1; ob_err = 1'b0; ob_stall0 = 1'b0;
        if (is_ldr) begin
          nx_ldr_req = 1'b1; nx_ldr_we = we; nx_ldr_addr = addr; nx_ldr_wdata = wdata;
        end else begin
          nx_cpu_req = 1'b1; nx_cpu_we = we; nx_cpu_addr = addr; nx_cpu_wdata = wdata;
        end
        for (int i = 0; i < 30; i++) begin
          step();
          if (i == 0) ob_stall0 = cpu_stall;
          if (mem_en) begin
            ob_en_cnt++;
            ob_en_off = cyc - 1 - n0;
            ob_we = mem_we; ob_addr = mem_addr; ob_wdata = mem_wdata;
          end
          if (is_ldr ? ldr_ack : cpu_ack) begin
            ob_ack_off = cyc - 1 - n0;
            ob_rdata   = is_ldr ? ldr_rdata : cpu_rdata;
`ifdef MEM_ARB_ALIGN_CHECK_EN
            ob_err     = cpu_err;
`endif
            break;
          end
        end
        nx_cpu_req = 1'b0;
        nx_ldr_req = 1'b0;
        step();
      endtask

      initial begin
        logic [31:0] a, wd, order;
        int nacks, both;
        logic ack_seen;
        nx_rst = 1'b1; rst = 1'b1;
        nx_cpu_req = 0; nx_cpu_we = 0; nx_cpu_addr = 0; nx_cpu_wdata = 0;
        nx_ldr_req = 0; nx_ldr_we = 0; nx_ldr_addr = 0; nx_ldr_wdata = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
        mem_rdata = 0; rd_pend = 0; rd_idx = 0; cyc = 0;
        t_en = 0; t_ack = 0; t_owner = 0; t_we = 0; t_addr = 0;
        for (int i = 0; i < 16; i++) begin
          env_mem[i] = $urandom();
          mdl_mem[i] = env_mem[i];
        end
        model_reset();

        // reset, then idle
        repeat (2) step();
        chk1("reset_busy", busy, 1'b0);
        nx_rst = 1'b0;
        repeat (3) step();
        chk1("idle_mem_en", mem_en, 1'b0);
        chk("idle_cpu_rdata", cpu_rdata, 32'h0);

        // CPU read
        env_mem[4] = 32'h2002_0005;
        mdl_mem[4] = 32'h2002_0005;
        run_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0);
        chk("rd_en_off", ob_en_off, 32'd1);
        chk("rd_en_cnt", ob_en_cnt, 32'd1);
        chk("rd_ack_off", ob_ack_off, 32'(LAT + 1));
        chk("rd_data", ob_rdata, 32'h2002_0005);
        chk1("rd_stall_first", ob_stall0, 1'b1);

`ifdef MEM_ARB_ALIGN_CHECK_EN
        // misaligned CPU read
        run_txn(1'b0, 1'b0, 32'h0000_0013, 32'h0);
        chk("mis_ack_off", ob_ack_off, 32'd1);
        chk("mis_en_cnt", ob_en_cnt, 32'd0);
        chk1("mis_err", ob_err, 1'b1);
        chk("mis_rdata", ob_rdata, 32'h2002_0005);
`endif

        // loader write
        run_txn(1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        chk("wr_en_cnt", ob_en_cnt, 32'd1);
        chk1("wr_mem_we", ob_we, 1'b1);
        chk("wr_mem_addr", ob_addr, 32'h0000_0040);
        chk("wr_mem_wdata", ob_wdata, 32'hDEAD_BEEF);
        chk("wr_ack_off", ob_ack_off, 32'(LAT + 1));
        chk("wr_ldr_rdata", ob_rdata, 32'h0);

        // both requesters held: CPU x4 then LDR, repeating
        nx_cpu_req = 1; nx_cpu_we = 0; nx_cpu_addr = 32'h20;
        nx_ldr_req = 1; nx_ldr_we = 0; nx_ldr_addr = 32'h24;
        order = '0; nacks = 0; both = 0;
        for (int i = 0; i < 10 * (LAT + 2); i++) begin
          step();
          if (cpu_ack && ldr_ack) both++;
          if (cpu_ack || ldr_ack) begin
            if (nacks < 10) order[nacks] = ldr_ack;
            nacks++;
          end
        end
        nx_cpu_req = 0; nx_ldr_req = 0;
        step();
        chk("starve_acks", 32'(nacks), 32'd10);
        chk("starve_order", order, 32'h0000_0210);
        chk("starve_dual_ack", 32'(both), 32'd0);

        // reset during a CPU write access, then the held request is served again
        wd = $urandom();
        nx_cpu_req = 1; nx_cpu_we = 1; nx_cpu_addr = 32'h08; nx_cpu_wdata = wd;
        step();
        nx_rst = 1'b1;
        step();
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        ack_seen = cpu_ack;
        step();
        ack_seen = ack_seen | cpu_ack;
        chk1("rst_no_ack", ack_seen, 1'b0);
        nx_rst = 1'b0;
        run_txn(1'b0, 1'b1, 32'h08, wd);
        chk("rst_retry_ack_off", ob_ack_off, 32'(LAT + 1));
        chk("rst_retry_en_cnt", ob_en_cnt, 32'd1);

        // random traffic
        for (int i = 0; i < 800; i++) begin
          step();
          if (nx_rst) nx_rst = 1'b0;
          else if ($urandom_range(0, 199) == 0) nx_rst = 1'b1;
          if (cpu_ack || !nx_cpu_req) begin
            if ($urandom_range(0, 1) == 0) begin
              a = $urandom();
              if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
              nx_cpu_req = 1'b1; nx_cpu_we = 1'($urandom_range(0, 1));
              nx_cpu_addr = a; nx_cpu_wdata = $urandom();
            end else nx_cpu_req = 1'b0;
          end else if ($urandom_range(0, 31) == 0) nx_cpu_req = 1'b0;
          if (ldr_ack || !nx_ldr_req) begin
            if ($urandom_range(0, 1) == 0) begin
              a = $urandom();
              a[1:0] = 2'b00;
              nx_ldr_req = 1'b1; nx_ldr_we = 1'($urandom_range(0, 1));
              nx_ldr_addr = a; nx_ldr_wdata = $urandom();
            end else nx_ldr_req = 1'b0;
          end else if ($urandom_range(0, 31) == 0) nx_ldr_req = 1'b0;
        end
        fin = 1'b1;
      end
    end
  endgenerate

  initial begin
    for (int i = 0; i < 30000; i++) begin
      if (g_cfg[0].fin && g_cfg[1].fin) break;
      @(posedge clk);
    end
    if (!(g_cfg[0].fin && g_cfg[1].fin)) begin
      total_cnt++;
      $display("FAIL timeout: stimulus did not complete, got unfinished, want finished");
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle MIPS core between two requesters: the core's memory stage (CPU) and the program loader / debug host (LDR).
- Serialises accesses through a small FSM and inserts wait states for a configurable memory latency.
- Drives a stall to the main controller so its state does not advance until the CPU access completes.

Parameters:
ADDR_WIDTH, 32, width of all address ports
DATA_WIDTH, 32, width of all data ports
MEM_LATENCY, 1, cycles from mem_en pulse to valid mem_rdata (>=1)
STARVE_LIMIT, 4, consecutive CPU grants tolerated while ldr_req pending before LDR is forced (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_WIDTH  byte address
cpu_wdata  in  DATA_WIDTH  write data
cpu_rdata  out  DATA_WIDTH  read data, valid with cpu_ack, held until next CPU read completes
cpu_ack  out  1  one-cycle completion pulse
cpu_stall  out  1  high while cpu_req && !cpu_ack
ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  loader request, same rules as CPU
ldr_rdata  out  DATA_WIDTH  loader read data, same rules as cpu_rdata
ldr_ack  out  1  one-cycle completion pulse
mem_en  out  1  memory strobe, exactly one cycle per access
mem_we  out  1  write enable, qualified by mem_en
mem_addr  out  ADDR_WIDTH  latched address
mem_wdata  out  DATA_WIDTH  latched write data
mem_rdata  in  DATA_WIDTH  memory read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - mem_en, mem_we, cpu_ack, ldr_ack, busy, cpu_stall = 0.
  - mem_addr, mem_wdata, cpu_rdata, ldr_rdata = 0.
  - Wait counter and starve counter = 0.
  - Any in-flight access is abandoned; no ack is issued.
- States:
  - IDLE: if any req, arbitrate, latch owner/addr/wdata/we, go to ACCESS; else stay.
  - ACCESS: mem_en=1 only in the first ACCESS cycle. Wait counter runs 0..MEM_LATENCY-1. On the cycle counter==MEM_LATENCY-1, capture mem_rdata into the owner's rdata register (reads only; writes leave rdata unchanged) and go to RESP.
  - RESP: owner's ack=1 for this cycle only; go to IDLE unconditionally.
- Latency: req first seen high in IDLE at cycle N -> mem_en at N+1 -> ack at N+MEM_LATENCY+1. Minimum request-to-request spacing is MEM_LATENCY+2 cycles.
- Arbitration (IDLE only):
  - CPU wins by default.
  - If both requests are high and starve count == STARVE_LIMIT, LDR wins.
  - Starve count increments (saturating at STARVE_LIMIT) on each CPU grant made while ldr_req=1.
  - Starve count clears on any LDR grant.
- Handshake:
  - Requester holds req, we, addr and wdata stable until ack.
  - Inputs are sampled only at the IDLE->ACCESS transition.
  - req dropped mid-access: the access still completes (writes are committed) and ack still pulses.
  - req still high in the IDLE cycle after ack is treated as a new request.
- cpu_stall is combinational: cpu_req && !cpu_ack, forced 0 while rst=1. It is high through the CPU's own ACCESS and through any LDR transaction that delays it.
- busy = (state != IDLE).
- mem_addr and mem_wdata hold their last values between accesses. mem_we=0 whenever mem_en=0.

Optional Feature:
- Macro: MEM_ARB_ALIGN_CHECK_EN.
- Defined:
  - Adds output cpu_err (1 bit).
  - A CPU request with cpu_addr[1:0]!=0 goes IDLE->RESP directly, with no ACCESS state and no mem_en.
  - In that RESP cycle, cpu_ack=1 and cpu_err=1 together; cpu_rdata is unchanged.
  - cpu_err resets to 0 and is 0 in every other cycle.
  - LDR accesses are never checked.
- Not defined: no cpu_err port; addresses pass through unchecked.

Test Plan:
- Reset then idle -> all outputs 0, busy=0, mem_en never asserts.
- MEM_LATENCY=1, CPU read addr 0x0000_0010, mem_rdata=0x2002_0005 -> mem_en at N+1, cpu_ack and cpu_rdata=0x2002_0005 at N+2, cpu_stall high N..N+1.
- MEM_LATENCY=3, LDR write addr 0x40 data 0xDEAD_BEEF -> single mem_en with mem_we=1, mem_addr=0x40, mem_wdata=0xDEAD_BEEF; ldr_ack at N+4; ldr_rdata unchanged.
- Both req held continuously, STARVE_LIMIT=4 -> grant order CPU,CPU,CPU,CPU,LDR,CPU,... Check each ack pulses exactly once per grant.
- rst asserted during ACCESS of a CPU write -> immediate IDLE, no cpu_ack, mem_en=0. After release, a pending cpu_req is re-serviced normally.
- With MEM_ARB_ALIGN_CHECK_EN, CPU read addr 0x0000_0013 -> cpu_ack and cpu_err at N+1, no mem_en, cpu_rdata unchanged.
